// File: rtl/cache_miss_sequencer_pkg.sv
// Shared definitions for the cache miss sequencer: FSM states and
// elaboration-time helpers for line geometry and address field layout.
package cache_miss_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_SEND,
    S_RF_REQ,
    S_RF_DATA,
    S_TAG_WR,
    S_DONE
  } state_t;

  function automatic int unsigned calc_beats(input int unsigned line_bytes,
                                             input int unsigned data_width);
    return (line_bytes * 8) / data_width;
  endfunction

  function automatic bit fields_fit(input int unsigned addr_w, input int unsigned tag_w,
                                    input int unsigned index_w, input int unsigned offset_w);
    return (tag_w + index_w + offset_w) == addr_w;
  endfunction

  // Tag field sits directly above index and offset.
  function automatic int unsigned tag_lsb(input int unsigned index_w,
                                          input int unsigned offset_w);
    return index_w + offset_w;
  endfunction

endpackage

// File: rtl/cache_miss_sequencer_victim_select.sv
// Replacement picker: lowest-index invalid way, otherwise the LRU hint.
module victim_select #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-1:0]         i_valid,
  input  logic [$clog2(WAYS)-1:0] i_lru_way,
  output logic [$clog2(WAYS)-1:0] o_way
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  // Scan from the top down so the lowest invalid index wins.
  always_comb begin
    o_way = i_lru_way;
    for (int unsigned i = WAYS; i > 0; i--) begin
      if (!i_valid[i-1]) o_way = WAY_W'(i - 1);
    end
  end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Miss sequencer: selects a victim, writes it back if dirty, refills the
// line beat by beat from memory, then writes the tag and pulses done.
module cache_miss_sequencer
  import cache_miss_sequencer_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned TAG_BITS        = 18,
  parameter int unsigned INDEX_BITS      = 8,
  parameter int unsigned OFFSET_BITS     = 6,
  parameter int unsigned WAYS            = 4,
  localparam int unsigned BEATS  = calc_beats(LINE_SIZE_BYTES, DATA_WIDTH),
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned BEAT_W = $clog2(BEATS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_miss_valid,
  output logic                       o_miss_ready,
  input  logic [ADDRESS_WIDTH-1:0]   i_miss_addr,
  input  logic [WAYS-1:0]            i_way_valid,
  input  logic [WAYS-1:0]            i_way_dirty,
  input  logic [WAYS*TAG_BITS-1:0]   i_way_tag,
  input  logic [WAY_W-1:0]           i_lru_way,
  output logic                       o_arr_en,
  output logic                       o_arr_we,
  output logic [INDEX_BITS-1:0]      o_arr_index,
  output logic [WAY_W-1:0]           o_arr_way,
  output logic [BEAT_W-1:0]          o_arr_beat,
  output logic [DATA_WIDTH-1:0]      o_arr_wdata,
  input  logic [DATA_WIDTH-1:0]      i_arr_rdata,
  output logic                       o_tag_we,
  output logic [TAG_BITS-1:0]        o_tag_wdata,
  output logic                       o_mem_valid,
  input  logic                       i_mem_ready,
  output logic                       o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic                       i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]      i_mem_rdata,
  output logic                       o_done,
  output logic [WAY_W-1:0]           o_done_way
);

  if (!fields_fit(ADDRESS_WIDTH, TAG_BITS, INDEX_BITS, OFFSET_BITS)) begin : g_addr_check
    $error("cache_miss_sequencer: TAG_BITS+INDEX_BITS+OFFSET_BITS must equal ADDRESS_WIDTH");
  end

  localparam int unsigned TAG_LSB = tag_lsb(INDEX_BITS, OFFSET_BITS);

  state_t                  r_state;
  logic [BEAT_W-1:0]       r_beat;
  logic [TAG_BITS-1:0]     r_tag;
  logic [INDEX_BITS-1:0]   r_index;
  logic [WAY_W-1:0]        r_victim;
  logic [TAG_BITS-1:0]     r_victim_tag;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic                    r_wb_fresh;

  logic [WAY_W-1:0]         w_victim;
  logic [TAG_BITS-1:0]      w_victim_tag;
  logic                     w_victim_dirty;
  logic                     w_last_beat;
  logic [ADDRESS_WIDTH-1:0] w_wb_addr;
  logic                     w_unused_offset;

  victim_select #(.WAYS(WAYS)) u_victim_select (
    .i_valid   (i_way_valid),
    .i_lru_way (i_lru_way),
    .o_way     (w_victim)
  );

  always_comb begin
    w_victim_tag = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (w_victim == WAY_W'(i)) w_victim_tag = i_way_tag[i*TAG_BITS +: TAG_BITS];
    end
  end

  assign w_victim_dirty  = i_way_valid[w_victim] & i_way_dirty[w_victim];
  assign w_last_beat     = (r_beat == BEAT_W'(BEATS - 1));
  assign w_wb_addr       = {r_victim_tag, r_index, {OFFSET_BITS{1'b0}}}
                         + ADDRESS_WIDTH'(r_beat) * ADDRESS_WIDTH'(DATA_WIDTH / 8);
  assign w_unused_offset = ^i_miss_addr[OFFSET_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_tag        <= '0;
      r_index      <= '0;
      r_victim     <= '0;
      r_victim_tag <= '0;
      r_wb_data    <= '0;
      r_wb_fresh   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_miss_valid) begin
            r_tag        <= i_miss_addr[TAG_LSB +: TAG_BITS];
            r_index      <= i_miss_addr[OFFSET_BITS +: INDEX_BITS];
            r_victim     <= w_victim;
            r_victim_tag <= w_victim_tag;
            r_beat       <= '0;
            r_state      <= w_victim_dirty ? S_WB_RD : S_RF_REQ;
          end
        end
        S_WB_RD: begin
          r_wb_fresh <= 1'b1;
          r_state    <= S_WB_SEND;
        end
        // Array read data is only valid in the first WB_SEND cycle; keep a copy for stalls.
        S_WB_SEND: begin
          r_wb_fresh <= 1'b0;
          if (r_wb_fresh) r_wb_data <= i_arr_rdata;
          if (i_mem_ready) begin
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_RF_REQ;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_state <= S_WB_RD;
            end
          end
        end
        S_RF_REQ: begin
          if (i_mem_ready) r_state <= S_RF_DATA;
        end
        S_RF_DATA: begin
          if (i_mem_rvalid) begin
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_TAG_WR;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_TAG_WR: r_state <= S_DONE;
        S_DONE:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_miss_ready = (r_state == S_IDLE);
  assign o_arr_index  = r_index;
  assign o_arr_way    = r_victim;
  assign o_arr_beat   = r_beat;
  assign o_tag_we     = (r_state == S_TAG_WR);
  assign o_tag_wdata  = r_tag;
  assign o_done       = (r_state == S_DONE);
  assign o_done_way   = r_victim;

  always_comb begin
    o_arr_en    = 1'b0;
    o_arr_we    = 1'b0;
    o_arr_wdata = '0;
    o_mem_valid = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      S_WB_RD: o_arr_en = 1'b1;
      S_WB_SEND: begin
        o_mem_valid = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = w_wb_addr;
        o_mem_wdata = r_wb_fresh ? i_arr_rdata : r_wb_data;
      end
      S_RF_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = {r_tag, r_index, {OFFSET_BITS{1'b0}}};
      end
      S_RF_DATA: begin
        o_arr_en    = i_mem_rvalid;
        o_arr_we    = i_mem_rvalid;
        o_arr_wdata = i_mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench for cache_miss_sequencer with a reactive memory responder
// and a one-cycle-latency data array read model.
module tb_cache_miss_sequencer;

  localparam int BEATS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_miss_valid = 1'b0;
  logic        o_miss_ready;
  logic [31:0] i_miss_addr = '0;
  logic [3:0]  i_way_valid = '0;
  logic [3:0]  i_way_dirty = '0;
  logic [71:0] i_way_tag = '0;
  logic [1:0]  i_lru_way = '0;
  logic        o_arr_en, o_arr_we;
  logic [7:0]  o_arr_index;
  logic [1:0]  o_arr_way;
  logic [3:0]  o_arr_beat;
  logic [31:0] o_arr_wdata;
  logic [31:0] i_arr_rdata = '0;
  logic        o_tag_we;
  logic [17:0] o_tag_wdata;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b0;
  logic        o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_done;
  logic [1:0]  o_done_way;

  cache_miss_sequencer #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE_BYTES(64),
    .TAG_BITS(18), .INDEX_BITS(8), .OFFSET_BITS(6), .WAYS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready), .i_miss_addr(i_miss_addr),
    .i_way_valid(i_way_valid), .i_way_dirty(i_way_dirty), .i_way_tag(i_way_tag),
    .i_lru_way(i_lru_way),
    .o_arr_en(o_arr_en), .o_arr_we(o_arr_we), .o_arr_index(o_arr_index),
    .o_arr_way(o_arr_way), .o_arr_beat(o_arr_beat), .o_arr_wdata(o_arr_wdata),
    .i_arr_rdata(i_arr_rdata),
    .o_tag_we(o_tag_we), .o_tag_wdata(o_tag_wdata),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_done(o_done), .o_done_way(o_done_way)
  );

  always #5 clk = ~clk;

  // Array model: read data appears one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (o_arr_en && !o_arr_we) i_arr_rdata <= 32'hA500_0000 | {22'd0, o_arr_way, 8'd0} | {28'd0, o_arr_beat};
    else                       i_arr_rdata <= 32'hEEEE_EEEE;
  end

  int total = 0, bad = 0;
  int n_arr_wr = 0, n_arr_rd = 0, n_mem_wr = 0, n_mem_rd = 0, n_tag = 0, n_done = 0, n_stall = 0;
  int arr_err = 0, mw_err = 0, rd_wr_at = 0;
  logic [31:0] rd_addr = '0, wb_base = '0;
  logic [17:0] last_tag = '0;
  logic [1:0]  done_way = '0, exp_way = '0;
  logic [7:0]  exp_idx = '0;

  int b_arr_wr, b_arr_rd, b_mem_wr, b_mem_rd, b_tag, b_done, b_stall, b_arr_err, b_mw_err;
  int lat, tag_lat, done_lat, acc_cyc, busy_ready;
  bit saw_done;

  // Passive monitor; cumulative counters, tests look at deltas.
  always @(negedge clk) begin
    if (o_arr_en && o_arr_we) begin
      if (!(o_arr_beat === 4'(n_arr_wr % BEATS) && o_arr_wdata === 32'hD000_0000 + 32'(n_arr_wr % BEATS)
            && o_arr_way === exp_way && o_arr_index === exp_idx)) arr_err++;
      n_arr_wr++;
    end
    if (o_arr_en && !o_arr_we) n_arr_rd++;
    if (o_mem_valid && !i_mem_ready) n_stall++;
    if (o_mem_valid && i_mem_ready) begin
      if (o_mem_we) begin
        if (!(o_mem_addr === wb_base + 32'((n_mem_wr % BEATS) * 4)
              && o_mem_wdata === (32'hA500_0000 | {22'd0, exp_way, 8'd0}) + 32'(n_mem_wr % BEATS))) mw_err++;
        n_mem_wr++;
      end else begin
        n_mem_rd++;
        rd_addr  = o_mem_addr;
        rd_wr_at = n_mem_wr;
      end
    end
    if (o_tag_we) begin n_tag++; last_tag = o_tag_wdata; end
    if (o_done) begin n_done++; done_way = o_done_way; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_arr_wr = n_arr_wr; b_arr_rd = n_arr_rd; b_mem_wr = n_mem_wr; b_mem_rd = n_mem_rd;
    b_tag = n_tag; b_done = n_done; b_stall = n_stall; b_arr_err = arr_err; b_mw_err = mw_err;
  endtask

  // Drives memory handshakes cycle by cycle until done (or an abort point / budget).
  task automatic run_miss(input int rv_gap, input int stall_beat, input int abort_beat,
                          input bit spur_wb, input bit hold_valid);
    int rd_pending = 0, phase = 0, stall_left = 2;
    bit accepted = 0, acc, rd_acc, was_beat, dn, prev_stall = 0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    saw_done = 0; busy_ready = 0; lat = 0; tag_lat = -1; done_lat = -1; acc_cyc = -1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (abort_beat >= 0 && o_mem_valid && o_mem_we && o_mem_addr == wb_base + 32'(abort_beat * 4)) return;
      i_mem_ready = 1'b1;
      if (stall_beat >= 0 && stall_left > 0 && o_mem_valid && o_mem_we
          && o_mem_addr == wb_base + 32'(stall_beat * 4)) begin
        i_mem_ready = 1'b0;
        stall_left--;
      end
      was_beat = (rd_pending > 0) && (phase % rv_gap == 0);
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      if (was_beat) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hD000_0000 + 32'(BEATS - rd_pending);
      end else if (spur_wb && o_mem_valid && o_mem_we) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0_0000;
      end
      @(negedge clk);
      if (prev_stall) begin
        chk("wb_hold_addr", o_mem_addr, prev_addr);
        chk("wb_hold_wdata", o_mem_wdata, prev_wdata);
      end
      prev_stall = o_mem_valid && !i_mem_ready;
      prev_addr  = o_mem_addr;
      prev_wdata = o_mem_wdata;
      acc    = i_miss_valid && o_miss_ready;
      rd_acc = o_mem_valid && !o_mem_we && i_mem_ready;
      dn     = o_done;
      if (accepted && o_miss_ready) busy_ready++;
      if (acc) begin accepted = 1; lat = 0; acc_cyc = cyc; end
      if (o_tag_we) tag_lat = lat;
      if (dn) begin done_lat = lat; saw_done = 1; end
      @(posedge clk);
      #1;
      lat++;
      if (acc && !hold_valid) i_miss_valid = 1'b0;
      if (was_beat) rd_pending--;
      if (rd_acc) begin rd_pending = BEATS; phase = 0; end
      else if (rd_pending > 0) phase++;
      if (dn) begin
        i_mem_rvalid = 1'b0;
        return;
      end
    end
  endtask

  task automatic check_refill(input logic [1:0] w, input logic [17:0] tag, input int nwr, input logic [31:0] ra);
    chk("done_seen", 64'(saw_done), 1);
    chk("arr_writes", n_arr_wr - b_arr_wr, BEATS);
    chk("arr_write_content", arr_err - b_arr_err, 0);
    chk("arr_reads", n_arr_rd - b_arr_rd, nwr);
    chk("mem_writes", n_mem_wr - b_mem_wr, nwr);
    chk("mem_write_content", mw_err - b_mw_err, 0);
    chk("mem_reads", n_mem_rd - b_mem_rd, 1);
    chk("refill_addr", rd_addr, ra);
    chk("refill_after_wb", rd_wr_at - b_mem_wr, nwr);
    chk("tag_writes", n_tag - b_tag, 1);
    chk("tag_wdata", last_tag, tag);
    chk("done_pulses", n_done - b_done, 1);
    chk("done_way", done_way, w);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_miss_ready", o_miss_ready, 1);
    chk("rst_mem_valid", o_mem_valid, 0);
    chk("rst_arr_en", o_arr_en, 0);
    chk("rst_tag_we", o_tag_we, 0);
    chk("rst_done", o_done, 0);
    chk("rst_done_way", o_done_way, 0);
    chk("rst_arr_index", o_arr_index, 0);
    rst = 1'b1;
    tick();

    // Spurious rvalid in IDLE
    snap();
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_0001;
    tick();
    i_mem_rvalid = 1'b0;
    tick();
    chk("idle_rvalid_ignored", n_arr_wr - b_arr_wr, 0);

    // Clean miss into first invalid way (way 2)
    snap();
    i_miss_addr = 32'h0001_2340; i_way_valid = 4'b1011; i_way_dirty = 4'b0000;
    i_way_tag = '0; i_lru_way = 2'd0; exp_way = 2'd2; exp_idx = 8'h8D;
    i_miss_valid = 1'b1;
    run_miss(1, -1, -1, 1'b0, 1'b0);
    check_refill(2'd2, 18'h4, 0, 32'h0001_2340);
    chk("clean_done_latency", done_lat, 3 + BEATS);
    chk("clean_tag_latency", tag_lat, 2 + BEATS);

    // All valid and clean, LRU way 3; requester holds valid into the next miss
    snap();
    i_miss_addr = 32'h1234_5680; i_way_valid = 4'b1111; i_lru_way = 2'd3;
    exp_way = 2'd3; exp_idx = 8'h5A;
    i_miss_valid = 1'b1;
    run_miss(1, -1, -1, 1'b0, 1'b1);
    check_refill(2'd3, 18'h48D1, 0, 32'h1234_5680);
    chk("busy_not_ready", busy_ready, 0);
    chk("ready_after_done", o_miss_ready, 1);

    // Dirty victim way 1, stall on write beat 5, spurious rvalid during WB_SEND
    snap();
    i_miss_addr = 32'h0001_2340; i_way_valid = 4'b1111; i_way_dirty = 4'b0010;
    i_way_tag = {18'h0, 18'h0, 18'h3FFFF, 18'h0}; i_lru_way = 2'd1;
    exp_way = 2'd1; exp_idx = 8'h8D; wb_base = 32'hFFFF_E340;
    run_miss(1, 5, -1, 1'b1, 1'b0);
    chk("second_miss_accept_cycle", acc_cyc, 0);
    check_refill(2'd1, 18'h4, BEATS, 32'h0001_2340);
    chk("wb_stall_cycles", n_stall - b_stall, 2);

    // Clean refill with rvalid every third cycle into invalid way 3
    snap();
    i_way_valid = 4'b0111; i_way_dirty = 4'b0000; i_way_tag = '0; i_lru_way = 2'd0;
    exp_way = 2'd3; exp_idx = 8'h8D;
    i_miss_valid = 1'b1;
    run_miss(3, -1, -1, 1'b0, 1'b0);
    check_refill(2'd3, 18'h4, 0, 32'h0001_2340);
    chk("gap_done_after_tag", done_lat - tag_lat, 1);

    // Reset during writeback beat 7
    snap();
    i_way_valid = 4'b1111; i_way_dirty = 4'b0001; i_way_tag = {54'h0, 18'h00ABC}; i_lru_way = 2'd0;
    exp_way = 2'd0; exp_idx = 8'h8D; wb_base = 32'h02AF_2340;
    i_miss_valid = 1'b1;
    run_miss(1, -1, 7, 1'b0, 1'b0);
    chk("abort_wb_beats_sent", n_mem_wr - b_mem_wr, 7);
    rst = 1'b0; i_miss_valid = 1'b0; i_mem_ready = 1'b0;
    tick();
    chk("abort_miss_ready", o_miss_ready, 1);
    chk("abort_mem_valid", o_mem_valid, 0);
    chk("abort_arr_en", o_arr_en, 0);
    rst = 1'b1;
    repeat (5) tick();
    chk("abort_no_tag", n_tag - b_tag, 0);
    chk("abort_no_done", n_done - b_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
